// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Core-side request/response bundle for the multiply/divide sequencer.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall;

  modport master (
    output start, funct3, a, b,
    input  busy, done, result, stall
  );

  modport slave (
    input  start, funct3, a, b,
    output busy, done, result, stall
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring
// divide step on a 2*XLEN-bit accumulator.
//   multiply: acc = {partial product high, multiplier}, operand = multiplicand
//   divide:   acc = {remainder, dividend/quotient},     operand = divisor
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              mode,
  output logic [2*XLEN-1:0] acc_nx
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
  always_comb begin
    // The carry out of the add lands in bit 2*XLEN-1 after the right shift.
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh = acc[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, operand};
    if (mode) begin
      if (!diff[XLEN]) acc_nx = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_nx = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_nx = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: accepts a request, stalls the
// core for XLEN iterations plus a sign-fixup cycle, and returns the result.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  state_t            state, state_nx;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc, acc_nx;
  logic [XLEN-1:0]   operand;
  logic [XLEN-1:0]   result_q;
  logic [2:0]        f3_q;
  logic              neg_main;
  logic              neg_rem;
  logic              div_mode;

  logic              accept;
  logic              a_signed, b_signed;
  logic              a_neg, b_neg;
  logic              div_op, b_zero, ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   special_res;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign accept   = bus.start & ((state == IDLE) | (state == DONE));
  assign div_mode = is_div(f3_q);

  // Decode the incoming request: signedness, magnitudes and the no-iteration cases.
  always_comb begin
    a_signed = (bus.funct3 != F3_MULHU) && (bus.funct3 != F3_DIVU) &&
               (bus.funct3 != F3_REMU);
    b_signed = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
               (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    a_neg    = a_signed & bus.a[XLEN-1];
    b_neg    = b_signed & bus.b[XLEN-1];
    mag_a    = a_neg ? -bus.a : bus.a;
    mag_b    = b_neg ? -bus.b : bus.b;
    div_op   = is_div(bus.funct3);
    b_zero   = (bus.b == '0);
    ovf      = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
               (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    special  = div_op & (b_zero | ovf);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    if (b_zero) special_res = bus.funct3[1] ? bus.a : '1;
    else        special_res = bus.funct3[1] ? '0 : bus.a;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc     (acc),
    .operand (operand),
    .mode    (div_mode),
    .acc_nx  (acc_nx)
  );

  // Sign correction and half selection applied in FIXUP.
  always_comb begin
    prod = neg_main ? -acc : acc;
    quo  = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (div_mode)             fix_res = f3_q[1] ? rem : quo;
    else if (f3_q == F3_MUL)  fix_res = prod[XLEN-1:0];
    else                      fix_res = prod[2*XLEN-1:XLEN];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; DONE accepts a new request directly without an IDLE bubble.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = special ? DONE : CALC;
        else        state_nx = IDLE;
      end
      CALC:    if (count == '0) state_nx = FIXUP;
      FIXUP:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs.
  always_comb begin
    bus.busy   = (state == CALC) | (state == FIXUP);
    bus.done   = (state == DONE);
    bus.stall  = accept | bus.busy;
    bus.result = result_q;
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      result_q <= '0;
      f3_q     <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (accept) begin
      f3_q     <= bus.funct3;
      neg_main <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      count    <= CW'(XLEN - 1);
      if (div_op) begin
        acc     <= {{XLEN{1'b0}}, mag_a};
        operand <= mag_b;
      end else begin
        acc     <= {{XLEN{1'b0}}, mag_b};
        operand <= mag_a;
      end
      if (special) result_q <= special_res;
    end else begin
      case (state)
        CALC: begin
          acc <= acc_nx;
          if (count != '0) count <= count - 1'b1;
        end
        FIXUP:   result_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver queues expected result and
// done cycle per request; a monitor checks them whenever done is seen.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int checks;
  int failures;

  typedef struct {
    logic [31:0] res;
    int unsigned at;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Checks result and latency of each done pulse against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        mon_e = q.pop_front();
        chk({mon_e.name, "_result"}, bus.result, mon_e.res);
        chk({mon_e.name, "_latency"}, cyc, mon_e.at);
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp, input int unsigned lat, input string name);
    bus.funct3 = f3;
    bus.a      = av;
    bus.b      = bv;
    bus.start  = 1'b1;
    q.push_back('{res: exp, at: cyc + lat, name: name});
    #1;
    chk({name, "_stall"}, bus.stall, 1);
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.a      = $urandom;
    bus.b      = $urandom;
    bus.funct3 = 3'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      chk({name, "_busy_in_done"}, bus.busy, 0);
    end
  endtask

  task automatic idle_check(input string name, input logic [31:0] held);
    @(posedge clk);
    #1;
    chk({name, "_busy_after"}, bus.busy, 0);
    chk({name, "_done_after"}, bus.done, 0);
    chk({name, "_held"}, bus.result, held);
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] exp, input int unsigned lat, input string name);
    issue(f3, av, bv, exp, lat, name);
    wait_done(name);
    idle_check(name, exp);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_result", bus.result, 0);
    chk("reset_stall", bus.stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3");
    run(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_ones");
    run(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh_ones");
    run(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34, "mulhsu");
    run(F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, "div_m7_2");
    run(F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, "rem_m7_2");
    run(F3_DIVU,   32'd100,        32'd7,         32'd14,        34, "divu_100_7");
    run(F3_REMU,   32'd100,        32'd7,         32'd2,         34, "remu_100_7");

    run(F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
    run(F3_REMU,   32'd5,          32'd0,         32'd5,         1, "remu_by0");
    run(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");

    // Start while busy is dropped; then a request in the DONE cycle chains on.
    issue(F3_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_ign");
    repeat (9) @(posedge clk);
    #1;
    bus.funct3 = F3_MUL;
    bus.a      = 32'd1;
    bus.b      = 32'd1;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    chk("ign_still_busy", bus.busy, 1);
    wait_done("divu_ign");
    issue(F3_REMU, 32'd100, 32'd7, 32'd2, 34, "remu_b2b");
    wait_done("remu_b2b");
    idle_check("remu_b2b", 32'd2);

    // Asynchronous reset in the middle of CALC.
    issue(F3_MUL, 32'h0001_2345, 32'h0000_0777, 32'h0, 34, "mul_abort");
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_stall", bus.stall, 0);
    chk("rst_mid_result", bus.result, 0);
    q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    run(F3_MUL, 32'd3, 32'd4, 32'd12, 34, "mul_3_4");

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
